slice_cfg_loader: RTL and testbench

- Configuration sequencer for one logic slice.
- Accepts bitstream words from the fabric config bus over a valid/ready stream.
- Serializes the words into CHAIN_W-bit beats and drives them onto the slice's config chain, qualified by cen on cclk.
- Counts beats against the slice frame length, zero-masks the padding, and reports completion.

---
 rtl/slice_cfg_loader.sv | 98 +++++++++
 tb/tb_slice_cfg_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/slice_cfg_loader.sv
// slice_cfg_loader: serializes config-bus words into CHAIN_W-bit beats for one slice's config chain.
//   cclk/rst_n            : config clock, asynchronous active-low reset
//   start/abort           : begin a frame (IDLE only) / cancel from any state
//   s_data/s_valid/s_ready: bitstream word stream, LSB shifted out first
//   cfg_data/cen          : beat to the slice, valid while cen is high
//   busy/done/beat_idx    : not-IDLE flag, end-of-frame pulse, beats issued in this frame
module slice_cfg_loader #(
  parameter int WORD_W = 32,
  parameter int CHAIN_W = 8,
  parameter int FRAME_BITS = 139,
  localparam int BEATS = (FRAME_BITS + CHAIN_W - 1) / CHAIN_W,
  localparam int BI_W = $clog2(BEATS + 1)
) (
  input  logic               cclk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [CHAIN_W-1:0] cfg_data,
  output logic               cen,
  output logic               busy,
  output logic               done,
  output logic [BI_W-1:0]    beat_idx
);
  localparam int RATIO = WORD_W / CHAIN_W;
  localparam int SUB_W = RATIO > 1 ? $clog2(RATIO) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [BI_W-1:0] beat_q, beat_d;
  logic s_ready_q, s_ready_d, cen_q, cen_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    sreg_d = sreg_q;
    sub_d = sub_q;
    beat_d = beat_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        beat_d = '0;
      end
      LOAD: if (s_valid) begin
        sreg_d = s_data;
        sub_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sreg_d = sreg_q >> CHAIN_W;
        sub_d = sub_q + SUB_W'(1);
        beat_d = beat_q + BI_W'(1);
        // the last beat of the frame ends it even mid-word; leftover word bits are dropped
        state_d = beat_q == BI_W'(BEATS - 1) ? DONE : sub_q == SUB_W'(RATIO - 1) ? LOAD : SHIFT;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      beat_d = '0;
    end
    // flags are registered from the next state so nothing combinational reaches cen from s_valid
    s_ready_d = state_d == LOAD;
    cen_d = state_d == SHIFT;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q <= '0;
      sub_q <= '0;
      beat_q <= '0;
      s_ready_q <= 1'b0;
      cen_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      sub_q <= sub_d;
      beat_q <= beat_d;
      s_ready_q <= s_ready_d;
      cen_q <= cen_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  // bits whose frame position lies past FRAME_BITS are padding and go out as zero
  always_comb
    for (int i = 0; i < CHAIN_W; i++)
      cfg_data[i] = cen_q && sreg_q[i] && (int'(beat_q) * CHAIN_W + i < FRAME_BITS);
  assign s_ready = s_ready_q;
  assign cen = cen_q;
  assign busy = busy_q;
  assign done = done_q;
  assign beat_idx = beat_q;
endmodule

// File: tb/tb_slice_cfg_loader.sv
// tb_slice_cfg_loader: directed checks of slice_cfg_loader against a frame-level model.
module tb_slice_cfg_loader;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic st[2], ab[2], sv[2], rdy[2], cen_o[2], busy_o[2], done_o[2];
  logic [31:0] sd[2];
  logic [7:0] cfg_o[2];
  logic [2:0] bi0;
  logic [4:0] bi1;
  logic [31:0] tbl[2][8];
  int hs[2], base[2];
  int checks = 0, errors = 0;
  bit chk_en = 0;
  int BT[2] = '{5, 18};
  int FB[2] = '{36, 139};
  int m_on[2], m_beats[2], m_got[2];
  logic [31:0] mw[2][8];
  int rc[64], rd[64], rn[64], rb[64], rr[64], ry[64];

  slice_cfg_loader #(.WORD_W(32), .CHAIN_W(8), .FRAME_BITS(36)) u36 (
    .cclk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .s_data(sd[0]), .s_valid(sv[0]),
    .s_ready(rdy[0]), .cfg_data(cfg_o[0]), .cen(cen_o[0]), .busy(busy_o[0]), .done(done_o[0]), .beat_idx(bi0));
  slice_cfg_loader u139 (
    .cclk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .s_data(sd[1]), .s_valid(sv[1]),
    .s_ready(rdy[1]), .cfg_data(cfg_o[1]), .cen(cen_o[1]), .busy(busy_o[1]), .done(done_o[1]), .beat_idx(bi1));

  // frame-level model: the frame is the concatenation of accepted words; a word is
  // requested whenever every beat of the words received so far has been issued
  for (genvar g = 0; g < 2; g++) begin : mdl
    assign sd[g] = tbl[g][(hs[g] - base[g]) & 7];
    always @(posedge clk) if (sv[g] && rdy[g]) hs[g] <= hs[g] + 1;
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        m_on[g] <= 0;
        m_beats[g] <= 0;
        m_got[g] <= 0;
      end else if (ab[g]) begin
        m_on[g] <= 0;
        m_beats[g] <= 0;
      end else if (m_on[g] == 0) begin
        if (st[g]) begin
          m_on[g] <= 1;
          m_beats[g] <= 0;
          m_got[g] <= 0;
        end
      end else if (m_beats[g] == BT[g]) m_on[g] <= 0;
      else if (m_beats[g] == 4 * m_got[g]) begin
        if (sv[g]) begin
          mw[g][m_got[g]] <= sd[g];
          m_got[g] <= m_got[g] + 1;
        end
      end else m_beats[g] <= m_beats[g] + 1;
  end

  function automatic int e_shift(int n);
    return int'(m_on[n] != 0 && m_beats[n] < BT[n] && m_beats[n] < 4 * m_got[n]);
  endfunction
  function automatic int e_load(int n);
    return int'(m_on[n] != 0 && m_beats[n] < BT[n] && m_beats[n] == 4 * m_got[n]);
  endfunction
  function automatic int e_done(int n);
    return int'(m_on[n] != 0 && m_beats[n] == BT[n]);
  endfunction
  function automatic int e_cfg(int n);
    int b;
    if (e_shift(n) == 0) return 0;
    b = int'((mw[n][m_beats[n] / 4] >> (8 * (m_beats[n] % 4))) & 32'hff);
    for (int i = 0; i < 8; i++) if (8 * m_beats[n] + i >= FB[n]) b = b & ~(1 << i);
    return b;
  endfunction

  task automatic chk(input string name, input int n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, n, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en)
      for (int n = 0; n < 2; n++) begin
        chk("cen", n, int'(cen_o[n]), e_shift(n));
        chk("s_ready", n, int'(rdy[n]), e_load(n));
        chk("done", n, int'(done_o[n]), e_done(n));
        chk("busy", n, int'(busy_o[n]), m_on[n]);
        chk("cfg_data", n, int'(cfg_o[n]), e_cfg(n));
        chk("beat_idx", n, n ? int'(bi1) : int'(bi0), m_beats[n]);
      end

  task automatic go(input int n);
    @(negedge clk);
    base[n] = hs[n];
    st[n] = 1;
  endtask
  task automatic step(input int n, input int k);
    @(negedge clk);
    st[n] = 0;
    rc[k] = int'(cen_o[n]);
    rd[k] = int'(cfg_o[n]);
    rn[k] = int'(done_o[n]);
    rb[k] = n ? int'(bi1) : int'(bi0);
    rr[k] = int'(rdy[n]);
    ry[k] = int'(busy_o[n]);
  endtask
  function automatic int cnt(input int sel, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += sel == 0 ? rc[k] : rn[k];
    return c;
  endfunction

  initial begin
    int c;
    st = '{0, 0};
    ab = '{0, 0};
    sv = '{0, 0};
    tbl[0][0] = 32'h44332211;
    tbl[0][1] = 32'h000000a5;
    for (int j = 0; j < 8; j++) begin
      tbl[0][j + 2 - 2 * (j / 6) * 3] = tbl[0][j + 2 - 2 * (j / 6) * 3];
      tbl[1][j] = {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)};
    end
    #2 rst_n = 0;
    #1;
    for (int n = 0; n < 2; n++) begin
      chk("rst_cen", n, int'(cen_o[n]), 0);
      chk("rst_busy", n, int'(busy_o[n]), 0);
      chk("rst_rdy", n, int'(rdy[n]), 0);
      chk("rst_cfg", n, int'(cfg_o[n]), 0);
    end
    chk("rst_bi", 0, int'(bi0), 0);
    chk_en = 1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    // back-to-back frame
    sv[0] = 1;
    go(0);
    for (int k = 1; k <= 10; k++) step(0, k);
    chk("b2b_rdy1", 0, rr[1], 1);
    for (int k = 2; k <= 5; k++) chk("b2b_beat", k, rd[k], 17 * (k - 1));
    chk("b2b_cen6", 0, rc[6], 0);
    chk("b2b_rdy6", 0, rr[6], 1);
    chk("b2b_cfg7", 0, rd[7], 5);
    chk("b2b_done8", 0, rn[8], 1);
    chk("b2b_cens", 0, cnt(0, 1, 10), 5);
    chk("b2b_bi9", 0, rb[9], 5);
    // stall in the second LOAD
    go(0);
    for (int k = 1; k <= 18; k++) begin
      step(0, k);
      if (k == 2) sv[0] = 0;
      if (k == 15) sv[0] = 1;
    end
    c = 0;
    for (int k = 6; k <= 15; k++) c += int'(rc[k] == 0 && rb[k] == 4 && rr[k] == 1);
    chk("stall_hold", 0, c, 10);
    chk("stall_cfg16", 0, rd[16], 5);
    chk("stall_done17", 0, rn[17], 1);
    // abort during the third beat, then start with abort
    go(0);
    for (int k = 1; k <= 4; k++) step(0, k);
    ab[0] = 1;
    step(0, 5);
    ab[0] = 0;
    chk("abort_b3", 0, rd[4], 8'h33);
    chk("abort_cen", 0, rc[5], 0);
    chk("abort_bi", 0, rb[5], 0);
    chk("abort_busy", 0, ry[5], 0);
    for (int k = 6; k <= 15; k++) step(0, k);
    chk("abort_nodone", 0, cnt(1, 5, 15), 0);
    @(negedge clk);
    st[0] = 1;
    ab[0] = 1;
    step(0, 1);
    ab[0] = 0;
    chk("abort_wins", 0, ry[1], 0);
    // start while busy is ignored
    go(0);
    for (int k = 1; k <= 20; k++) begin
      step(0, k);
      if (k == 3) st[0] = 1;
    end
    chk("restart_done", 0, cnt(1, 1, 20), 1);
    chk("restart_cens", 0, cnt(0, 1, 20), 5);
    chk("restart_done8", 0, rn[8], 1);
    // asynchronous reset during the second beat
    go(0);
    for (int k = 1; k <= 3; k++) step(0, k);
    #1 rst_n = 0;
    #1;
    chk("rmid_cen", 0, int'(cen_o[0]), 0);
    chk("rmid_busy", 0, int'(busy_o[0]), 0);
    chk("rmid_cfg", 0, int'(cfg_o[0]), 0);
    chk("rmid_bi", 0, int'(bi0), 0);
    @(negedge clk);
    #1 rst_n = 1;
    go(0);
    for (int k = 1; k <= 10; k++) step(0, k);
    chk("rmid_cfg2", 0, rd[2], 8'h11);
    chk("rmid_done8", 0, rn[8], 1);
    chk("rmid_cens", 0, cnt(0, 1, 10), 5);
    // default frame length
    sv[1] = 1;
    go(1);
    for (int k = 1; k <= 40; k++) step(1, k);
    c = 0;
    for (int k = 40; k >= 1; k--) if (rn[k] != 0) c = k;
    chk("dflt_done_at", 1, c, 24);
    chk("dflt_cens", 1, cnt(0, 1, 40), 18);
    chk("dflt_cfg7", 1, rd[7], 4);
    chk("dflt_last", 1, rd[23], 1);
    chk("dflt_bi", 1, rb[25], 18);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
